// File: rtl/decoder_onehot_seq_if.sv
// Command port of the one-hot decoder: valid/ready handshake
// carrying a binary select and a drive mode.
interface decoder_onehot_seq_if #(
   parameter int SEL_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] in_sel;
   logic [1:0]       in_mode;

   modport master (
      output in_valid,
      output in_sel,
      output in_mode,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_sel,
      input  in_mode,
      output in_ready
   );
endinterface

// File: rtl/decoder_onehot_seq.sv
// Binary to one-hot decoder with registered output and
// HOLD / PULSE / SCAN / CLEAR sequenced drive modes.
module decoder_onehot_seq #(
   parameter int SEL_W     = 3,
   parameter int PULSE_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   decoder_onehot_seq_if.slave     cmd,
   output logic [(1<<SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        out_idx,
   output logic                    out_active,
   output logic                    busy,
   output logic                    done
);

   localparam int OUT_W = 1 << SEL_W;

   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_PULSE = 2'b01;
   localparam logic [1:0] M_SCAN  = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      PULSE,
      SCAN
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               on_d;
   logic               done_q, done_d;
   logic [OUT_W-1:0]   out_q;
   logic               accept;

   assign cmd.in_ready = (state_q == IDLE) || (state_q == HOLD);
   assign accept       = cmd.in_valid && cmd.in_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      on_d    = (state_q != IDLE);
      done_d  = 1'b0;
      unique case (state_q)
         IDLE, HOLD: begin
            if (accept) begin
               idx_d = cmd.in_sel;
               on_d  = 1'b1;
               unique case (cmd.in_mode)
                  M_HOLD: begin
                     state_d = HOLD;
                  end
                  M_PULSE: begin
                     state_d = PULSE;
                     cnt_d   = CNT_W'(PULSE_LEN - 1);
                  end
                  M_SCAN: begin
                     state_d = SCAN;
                     cnt_d   = CNT_W'(OUT_W - 1);
                  end
                  default: begin
                     state_d = IDLE;
                     idx_d   = '0;
                     on_d    = 1'b0;
                  end
               endcase
            end
         end
         PULSE, SCAN: begin
            if (cnt_q == '0) begin
               // sequence over: blank output and flag completion together
               state_d = IDLE;
               idx_d   = '0;
               on_d    = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (state_q == SCAN) begin
                  idx_d = idx_q + SEL_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            on_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         out_q   <= on_d ? (OUT_W'(1) << idx_d) : '0;
      end
   end

   assign out        = out_q;
   assign out_idx    = idx_q;
   assign out_active = |out_q;
   assign busy       = (state_q == PULSE) || (state_q == SCAN);
   assign done       = done_q;

   a_onehot0 : assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(out_q)
   );

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench for decoder_onehot_seq: schedule-queue model compared
// every cycle, plus directed literal checks.
module tb_decoder_onehot_seq;

   localparam int PL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decoder_onehot_seq_if #(.SEL_W(3)) ifc ();
   decoder_onehot_seq_if #(.SEL_W(4)) ifc4 ();

   logic [7:0]  out;
   logic [2:0]  out_idx;
   logic        out_active, busy, done;
   logic [15:0] out4;
   logic [3:0]  out_idx4;
   logic        out_active4, busy4, done4;

   decoder_onehot_seq #(.SEL_W(3), .PULSE_LEN(PL), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (ifc.slave),
      .out        (out),
      .out_idx    (out_idx),
      .out_active (out_active),
      .busy       (busy),
      .done       (done)
   );

   decoder_onehot_seq #(.SEL_W(4), .PULSE_LEN(PL), .CNT_W(8)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (ifc4.slave),
      .out        (out4),
      .out_idx    (out_idx4),
      .out_active (out_active4),
      .busy       (busy4),
      .done       (done4)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each accepted sequence becomes a list of per-cycle indices
   // (-1 = dark), ending with a dark entry that carries done.
   int q_idx[$];
   bit q_done[$];
   int held = -1;
   int cur = -1;
   bit mdone = 1'b0;
   bit mready = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_idx.delete();
         q_done.delete();
         held = -1;
         cur = -1;
         mdone = 1'b0;
         mready = 1'b1;
      end else begin
         if (ifc.in_valid && mready) begin
            q_idx.delete();
            q_done.delete();
            held = -1;
            case (ifc.in_mode)
               2'd0: held = int'(ifc.in_sel);
               2'd1: begin
                  for (int i = 0; i < PL; i++) begin
                     q_idx.push_back(int'(ifc.in_sel));
                     q_done.push_back(1'b0);
                  end
                  q_idx.push_back(-1);
                  q_done.push_back(1'b1);
               end
               2'd2: begin
                  for (int i = 0; i < 8; i++) begin
                     q_idx.push_back((int'(ifc.in_sel) + i) % 8);
                     q_done.push_back(1'b0);
                  end
                  q_idx.push_back(-1);
                  q_done.push_back(1'b1);
               end
               default: held = -1;
            endcase
         end
         if (q_idx.size() > 0) begin
            cur = q_idx.pop_front();
            mdone = q_done.pop_front();
         end else begin
            cur = held;
            mdone = 1'b0;
         end
         mready = (q_idx.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic [7:0] eo;
         logic [2:0] ei;
         eo = (cur < 0) ? 8'h00 : (8'h01 << cur);
         ei = (cur < 0) ? 3'd0 : 3'(cur);
         chk("model",
             {out, out_idx, out_active, busy, done, ifc.in_ready},
             {eo, ei, (cur >= 0), !mready, mdone, mready});
         chk("onehot0", longint'($onehot0(out)), 1);
      end
   end

   logic [7:0] scan_exp [8] = '{8'h40, 8'h80, 8'h01, 8'h02,
                                8'h04, 8'h08, 8'h10, 8'h20};

   task automatic cmd(input logic [2:0] s, input logic [1:0] m);
      ifc.in_valid = 1'b1;
      ifc.in_sel   = s;
      ifc.in_mode  = m;
      @(negedge clk);
      ifc.in_valid = 1'b0;
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_sel    = '0;
      ifc.in_mode   = '0;
      ifc4.in_valid = 1'b0;
      ifc4.in_sel   = '0;
      ifc4.in_mode  = '0;
      repeat (2) @(negedge clk);
      chk("rst_out", out, 8'h00);
      chk("rst_ready", ifc.in_ready, 1);
      chk("rst_busy", busy, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      cmd(3'd5, 2'd0);
      chk("hold5_out", out, 8'h20);
      chk("hold5_idx", out_idx, 5);
      cmd(3'd2, 2'd0);
      chk("hold2_out", out, 8'h04);
      cmd(3'd0, 2'd3);
      chk("clear_out", out, 8'h00);

      ifc.in_valid = 1'b1;
      ifc.in_sel   = 3'd7;
      ifc.in_mode  = 2'd1;
      @(negedge clk);
      ifc.in_sel  = 3'd1;
      ifc.in_mode = 2'd0;
      for (int i = 0; i < PL; i++) begin
         chk("pulse_out", out, 8'h80);
         chk("pulse_ready", ifc.in_ready, 0);
         @(negedge clk);
      end
      chk("pulse_end_out", out, 8'h00);
      chk("pulse_done", done, 1);
      chk("pulse_end_ready", ifc.in_ready, 1);
      ifc.in_sel  = 3'd3;
      ifc.in_mode = 2'd1;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      chk("b2b_out", out, 8'h08);
      chk("b2b_busy", busy, 1);
      repeat (PL) @(negedge clk);
      chk("b2b_done", done, 1);
      @(negedge clk);

      cmd(3'd6, 2'd2);
      for (int i = 0; i < 8; i++) begin
         chk("scan_out", out, scan_exp[i]);
         chk("scan_idx", out_idx, (6 + i) % 8);
         @(negedge clk);
      end
      chk("scan_end_out", out, 8'h00);
      chk("scan_done", done, 1);
      @(negedge clk);

      cmd(3'd0, 2'd2);
      repeat (4) @(negedge clk);
      chk("pre_rst_out", out, 8'h10);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_out", out, 8'h00);
      chk("async_rst_busy", busy, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", ifc.in_ready, 1);
      chk("post_rst_out", out, 8'h00);

      ifc4.in_valid = 1'b1;
      ifc4.in_sel   = 4'd15;
      ifc4.in_mode  = 2'd0;
      @(negedge clk);
      ifc4.in_valid = 1'b0;
      chk("w4_out", out4, 16'h8000);
      chk("w4_idx", out_idx4, 15);

      for (int i = 0; i < 10000; i++) begin
         ifc.in_valid = ($urandom_range(0, 3) != 0);
         ifc.in_sel   = 3'($urandom_range(0, 7));
         ifc.in_mode  = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      ifc.in_valid = 1'b0;
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
